// File: rtl/a2d_sched.sv
// a2d_sched: A2D conversion scheduler. Sequences brake/batt/curr/torque slots
// over one SPI master and holds the latest 12-bit result per channel.
module a2d_sched #(
    parameter bit          FAST_SIM = 1'b1,
    parameter int unsigned TMO_CYC  = 1023
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cnv_wrt,
    output logic [15:0] cnv_cmd,
    input  logic        cnv_done,
    input  logic [15:0] cnv_rd_data,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        sample_vld,
    output logic [1:0]  sample_chan,
    output logic        overrun,
    output logic        tmo_err
);

    localparam logic [13:0] INT_MAX  = FAST_SIM ? 14'd511 : 14'd16383;
    localparam int unsigned TMO_W    = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAP, READ, WAIT2, STORE} state_t;

    state_t           state, nxt_state;
    logic [13:0]      int_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       slot_ptr;
    logic [2:0]       slot_ch;
    logic [1:0]       slot_code;
    logic             tick;
    logic             in_wait;
    logic             tmo_hit;
    logic             unused_rd_bits;

    assign tick    = (int_cnt == INT_MAX);
    assign in_wait = (state == WAIT1) || (state == WAIT2);
    // cnv_done on the last allowed cycle takes priority over the timeout
    assign tmo_hit = in_wait && (tmo_cnt == TMO_LAST) && !cnv_done;
    assign unused_rd_bits = &{1'b0, cnv_rd_data[15:12]};

    always_comb begin
        slot_ch   = 3'd3;
        slot_code = 2'd2;
        case (slot_ptr)
            3'd1: begin slot_ch = 3'd0; slot_code = 2'd0; end
            3'd3: begin slot_ch = 3'd1; slot_code = 2'd1; end
            3'd5: begin slot_ch = 3'd4; slot_code = 2'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:  if (tick) nxt_state = CMD;
            CMD:   nxt_state = WAIT1;
            WAIT1: if (cnv_done) nxt_state = GAP;
                   else if (tmo_hit) nxt_state = IDLE;
            GAP:   nxt_state = READ;
            READ:  nxt_state = WAIT2;
            WAIT2: if (cnv_done) nxt_state = STORE;
                   else if (tmo_hit) nxt_state = IDLE;
            STORE: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        cnv_wrt     = (state == CMD) || (state == READ);
        cnv_cmd     = cnv_wrt ? {2'b00, slot_ch, 11'h000} : '0;
        sample_vld  = (state == STORE);
        sample_chan = sample_vld ? slot_code : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_cnt  <= '0;
            tmo_cnt  <= '0;
            slot_ptr <= '0;
            batt     <= '0;
            curr     <= '0;
            brake    <= '0;
            torque   <= '0;
            overrun  <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            int_cnt <= tick ? '0 : int_cnt + 14'd1;
            // Cleared outside the WAIT states, so it is zero on every WAIT entry
            tmo_cnt <= in_wait ? tmo_cnt + 1'b1 : '0;
            if (tick && state != IDLE) overrun <= 1'b1;
            if (tmo_hit) tmo_err <= 1'b1;
            if (state == STORE || tmo_hit)
                slot_ptr <= (slot_ptr == 3'd5) ? 3'd0 : slot_ptr + 3'd1;
            if (state == WAIT2 && cnv_done) begin
                case (slot_code)
                    2'd0: batt   <= cnv_rd_data[11:0];
                    2'd1: curr   <= cnv_rd_data[11:0];
                    2'd2: brake  <= cnv_rd_data[11:0];
                    default: torque <= cnv_rd_data[11:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_a2d_sched.sv
// Self-checking bench for a2d_sched: SPI responder model, scoreboard of
// expected samples, and one task per scenario.
module tb_a2d_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnv_wrt;
    logic [15:0] cnv_cmd;
    logic        cnv_done = 1'b0;
    logic [15:0] cnv_rd_data = '0;
    logic [11:0] batt, curr, brake, torque;
    logic        sample_vld;
    logic [1:0]  sample_chan;
    logic        overrun, tmo_err;

    a2d_sched #(.FAST_SIM(1'b1), .TMO_CYC(1023)) dut (
        .clk(clk), .rst(rst), .cnv_wrt(cnv_wrt), .cnv_cmd(cnv_cmd),
        .cnv_done(cnv_done), .cnv_rd_data(cnv_rd_data),
        .batt(batt), .curr(curr), .brake(brake), .torque(torque),
        .sample_vld(sample_vld), .sample_chan(sample_chan),
        .overrun(overrun), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int spi_delay  = 40;
    int drop_slot  = -1;
    int cyc        = 0;
    int cd         = -1;
    bit phase      = 1'b0;
    int slot_no    = 0;
    logic [2:0] pend_ch = '0;
    logic [7:0] pend_slot = '0;
    bit pend_push  = 1'b0;
    logic [15:0] first_cmd = '0;
    int rd_wrt_cyc = 0;
    int wrt_total  = 0;
    int vld_total  = 0;

    logic [13:0] exp_q[$];
    logic [15:0] cmd_log[$];
    int          start_cyc[$];

    function automatic logic [1:0] chan_code(input logic [2:0] ch);
        case (ch)
            3'd0: return 2'd0;
            3'd1: return 2'd1;
            3'd3: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // SPI responder plus sample scoreboard, evaluated mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            cnv_done = 1'b0;
            if (rst) begin
                phase = 1'b0;
                slot_no = 0;
                pend_push = 1'b0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    cnv_done = 1'b1;
                    cnv_rd_data = {4'hF, 1'b0, pend_ch, pend_slot};
                    if (pend_push) exp_q.push_back({chan_code(pend_ch), 1'b0, pend_ch, pend_slot});
                    cd = -1;
                end
            end
            if (cnv_wrt && !rst) begin
                wrt_total++;
                if (!phase) begin
                    cmd_log.push_back(cnv_cmd);
                    start_cyc.push_back(cyc);
                    first_cmd = cnv_cmd;
                end else begin
                    n_tests++;
                    if (cnv_cmd !== first_cmd) begin
                        n_fail++;
                        $display("FAIL read_cmd: got %h expected %h", cnv_cmd, first_cmd);
                    end
                    rd_wrt_cyc = cyc;
                end
                pend_ch   = cnv_cmd[13:11];
                pend_slot = slot_no[7:0];
                pend_push = phase;
                cd = (phase && slot_no == drop_slot) ? -1 : spi_delay;
                if (phase) slot_no++;
                phase = ~phase;
            end
            if (sample_vld) begin
                vld_total++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_sample: chan %0d with none expected", sample_chan);
                end else begin
                    logic [13:0] e;
                    logic [11:0] v;
                    e = exp_q.pop_front();
                    case (e[13:12])
                        2'd0: v = batt;
                        2'd1: v = curr;
                        2'd2: v = brake;
                        default: v = torque;
                    endcase
                    if ({sample_chan, v} !== e) begin
                        n_fail++;
                        $display("FAIL sample: got chan %0d val %h expected chan %0d val %h",
                                 sample_chan, v, e[13:12], e[11:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        exp_q.delete();
        cmd_log.delete();
        start_cyc.delete();
        wrt_total = 0;
        vld_total = 0;
        drop_slot = -1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cnv_wrt, cnv_cmd, sample_vld, sample_chan, overrun, tmo_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got wrt %b cmd %h vld %b chan %0d ovr %b tmo %b expected all 0",
                     cnv_wrt, cnv_cmd, sample_vld, sample_chan, overrun, tmo_err);
        end
        n_tests++;
        if ({batt, curr, brake, torque} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h %h %h %h expected 0", batt, curr, brake, torque);
        end
    endtask

    task automatic test_first_slot();
        do_reset();
        spi_delay = 40;
        for (int i = 0; i < 700 && !sample_vld; i++) step();
        n_tests++;
        if (!sample_vld) begin
            n_fail++;
            $display("FAIL first_sample_timeout: got no sample_vld expected one");
        end else begin
            n_tests++;
            if (sample_chan !== 2'd2 || brake !== 12'h300) begin
                n_fail++;
                $display("FAIL first_sample: got chan %0d brake %h expected chan 2 brake 300",
                         sample_chan, brake);
            end
        end
        n_tests++;
        if (cmd_log.size() < 1 || cmd_log[0] !== 16'h1800) begin
            n_fail++;
            $display("FAIL first_cmd: got %h expected 1800", cmd_log.size() > 0 ? cmd_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_order();
        int prev_wrt;
        int seq[6] = '{3, 0, 3, 1, 3, 4};
        do_reset();
        spi_delay = 40;
        prev_wrt = 0;
        for (int i = 0; i < 7000 && vld_total < 12; i++) begin
            step();
            if (sample_vld) begin
                n_tests++;
                if (wrt_total - prev_wrt !== 2) begin
                    n_fail++;
                    $display("FAIL wrt_per_slot: got %0d expected 2", wrt_total - prev_wrt);
                end
                prev_wrt = wrt_total;
            end
        end
        n_tests++;
        if (vld_total !== 12 || cmd_log.size() < 12) begin
            n_fail++;
            $display("FAIL order_slots: got %0d samples %0d cmds expected 12", vld_total, cmd_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_tests++;
                if (32'(cmd_log[i][13:11]) !== seq[i % 6]) begin
                    n_fail++;
                    $display("FAIL order_ch[%0d]: got %0d expected %0d", i, cmd_log[i][13:11], seq[i % 6]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        spi_delay = 40;
        drop_slot = 1;
        for (int i = 0; i < 3000 && !tmo_err; i++) step();
        n_tests++;
        if (!tmo_err || cyc - rd_wrt_cyc !== 1023) begin
            n_fail++;
            $display("FAIL tmo_latency: got tmo %b after %0d cycles expected 1 after 1023",
                     tmo_err, cyc - rd_wrt_cyc);
        end
        n_tests++;
        if (batt !== 12'h000) begin
            n_fail++;
            $display("FAIL tmo_batt: got %h expected 000", batt);
        end
        for (int i = 0; i < 700 && cmd_log.size() < 3; i++) step();
        n_tests++;
        if (cmd_log.size() < 3 || cmd_log[2] !== 16'h1800) begin
            n_fail++;
            $display("FAIL tmo_next_cmd: got %h expected 1800", cmd_log.size() > 2 ? cmd_log[2] : 16'hxxxx);
        end
        drop_slot = -1;
    endtask

    task automatic test_overrun();
        do_reset();
        spi_delay = 600;
        for (int i = 0; i < 6000 && vld_total < 3; i++) step();
        n_tests++;
        if (overrun !== 1'b1 || tmo_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_flags: got ovr %b tmo %b expected 1 0", overrun, tmo_err);
        end
        n_tests++;
        if (vld_total !== 3 || start_cyc.size() < 3) begin
            n_fail++;
            $display("FAIL overrun_slots: got %0d samples expected 3", vld_total);
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_tests++;
                if (start_cyc[i] - start_cyc[i-1] !== 1536) begin
                    n_fail++;
                    $display("FAIL overrun_spacing[%0d]: got %0d expected 1536",
                             i, start_cyc[i] - start_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        spi_delay = 40;
        for (int i = 0; i < 1400 && wrt_total < 4; i++) step();
        n_tests++;
        if (wrt_total < 4 || brake !== 12'h300) begin
            n_fail++;
            $display("FAIL midrst_setup: got %0d wrts brake %h expected 4 and 300", wrt_total, brake);
        end
        repeat (38) step();
        rst = 1'b1;
        step();
        cmd_log.delete();
        rst = 1'b0;
        n_tests++;
        if ({cnv_wrt, cnv_cmd, sample_vld, sample_chan, overrun, tmo_err,
             batt, curr, brake, torque} !== '0) begin
            n_fail++;
            $display("FAIL midrst_values: got wrt %b cmd %h vld %b brake %h batt %h expected all 0",
                     cnv_wrt, cnv_cmd, sample_vld, brake, batt);
        end
        repeat (5) step();
        n_tests++;
        if (brake !== 12'h000 || batt !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_ignore_done: got brake %h batt %h expected 000", brake, batt);
        end
        for (int i = 0; i < 700 && cmd_log.size() < 1; i++) step();
        n_tests++;
        if (cmd_log.size() < 1 || cmd_log[0] !== 16'h1800) begin
            n_fail++;
            $display("FAIL midrst_next_cmd: got %h expected 1800", cmd_log.size() > 0 ? cmd_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_done_at_timeout();
        do_reset();
        spi_delay = 1023;
        for (int i = 0; i < 3500 && vld_total < 1; i++) step();
        n_tests++;
        if (vld_total !== 1 || brake !== 12'h300 || tmo_err !== 1'b0) begin
            n_fail++;
            $display("FAIL done_at_tmo: got %0d samples brake %h tmo %b expected 1 300 0",
                     vld_total, brake, tmo_err);
        end
        spi_delay = 40;
    endtask

    initial begin
        test_reset();
        test_first_slot();
        test_order();
        test_timeout();
        test_overrun();
        test_reset_mid_slot();
        test_done_at_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
